// File: rtl/wide_alu_seq_pkg.sv
// Shared encodings for the multi-precision ALU sequencer.
// Opcodes, ALU select codes and FSM states.
package wide_alu_seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SHL1 = 3'd5;

    localparam logic [3:0] ALU_PASSA = 4'h0;
    localparam logic [3:0] ALU_ADDC  = 4'h3;
    localparam logic [3:0] ALU_AND   = 4'h9;
    localparam logic [3:0] ALU_OR    = 4'hA;
    localparam logic [3:0] ALU_XOR   = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL1);
    endfunction

    function automatic logic op_is_rsvd(input logic [2:0] op);
        return op > OP_SHL1;
    endfunction

endpackage

// File: rtl/wide_alu_seq.sv
// Multi-precision sequencer: drives a 64-bit ALU one slice per
// cycle, LS word first, chaining carry and accumulating flags.
module wide_alu_seq
    import wide_alu_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic                  ci,
    input  logic [WORDS*64-1:0]   a,
    input  logic [WORDS*64-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [WORDS*64-1:0]   result,
    output logic                  cout,
    output logic                  oflow,
    output logic                  neg,
    output logic                  zero,
    output logic                  err,
    output logic [63:0]           alu_a,
    output logic [63:0]           alu_b,
    output logic                  alu_cin,
    output logic [3:0]            alu_s,
    input  logic [63:0]           alu_o,
    input  logic                  alu_cout,
    input  logic                  alu_oflow
);

    localparam int W  = WORDS * 64;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_result;
    logic [2:0]      r_op;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic            r_zacc;
    logic            r_cout;
    logic            r_oflow;
    logic            r_neg;
    logic            r_zero;
    logic            r_err;
    logic [63:0]     w_a_sl;
    logic [63:0]     w_b_sl;
    logic            w_arith;
    logic            w_last;
    logic            w_o_zero;

    assign w_a_sl   = r_a[{r_idx, 6'd0} +: 64];
    assign w_b_sl   = r_b[{r_idx, 6'd0} +: 64];
    assign w_arith  = op_is_arith(r_op);
    assign w_last   = (r_idx == LAST);
    assign w_o_zero = (alu_o == 64'd0);

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;
    assign cout   = r_cout;
    assign oflow  = r_oflow;
    assign neg    = r_neg;
    assign zero   = r_zero;
    assign err    = r_err;

    // Next state, and the ALU slice drive while running
    always_comb begin
        w_next  = r_state;
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        alu_s   = ALU_PASSA;
        unique case (r_state)
            ST_IDLE: begin
                if (start)
                    w_next = op_is_rsvd(op) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                alu_a   = w_a_sl;
                alu_cin = r_carry;
                case (r_op)
                    OP_ADD:  begin alu_b = w_b_sl;  alu_s = ALU_ADDC; end
                    OP_SUB:  begin alu_b = ~w_b_sl; alu_s = ALU_ADDC; end
                    OP_SHL1: begin alu_b = w_a_sl;  alu_s = ALU_ADDC; end
                    OP_AND:  begin alu_b = w_b_sl;  alu_s = ALU_AND;  end
                    OP_OR:   begin alu_b = w_b_sl;  alu_s = ALU_OR;   end
                    OP_XOR:  begin alu_b = w_b_sl;  alu_s = ALU_XOR;  end
                    default: ;
                endcase
                if (w_last)
                    w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand latch, per-slice accumulation and final flag capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_op     <= OP_ADD;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_zacc   <= 1'b0;
            r_cout   <= 1'b0;
            r_oflow  <= 1'b0;
            r_neg    <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_op   <= op;
                        r_idx  <= '0;
                        r_zacc <= 1'b1;
                        r_err  <= 1'b0;
                        if (op == OP_SUB)
                            r_carry <= 1'b1;
                        else if (op == OP_ADD || op == OP_SHL1)
                            r_carry <= ci;
                        else
                            r_carry <= 1'b0;
                        if (op_is_rsvd(op)) begin
                            r_result <= '0;
                            r_err    <= 1'b1;
                            r_cout   <= 1'b0;
                            r_oflow  <= 1'b0;
                            r_neg    <= 1'b0;
                            r_zero   <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    r_result[{r_idx, 6'd0} +: 64] <= alu_o;
                    r_carry <= w_arith & alu_cout;
                    r_zacc  <= r_zacc & w_o_zero;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_oflow <= w_arith & alu_oflow;
                        r_neg   <= alu_o[63];
                        r_cout  <= w_arith & alu_cout;
                        r_zero  <= r_zacc & w_o_zero;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_alu_seq.sv
// Bench for wide_alu_seq with a behavioural 64-bit ALU alongside.
// Expected results are queued at start and compared on done.
module tb_wide_alu_seq;
    import wide_alu_seq_pkg::*;

    localparam int WORDS = 4;
    localparam int W     = WORDS * 64;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         oflow;
        logic         neg;
        logic         zero;
        logic         err;
        logic         chk_flags;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      op;
    logic            ci;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            busy;
    logic            done;
    logic [W-1:0]    result;
    logic            cout;
    logic            oflow;
    logic            neg;
    logic            zero;
    logic            err;
    logic [63:0]     alu_a;
    logic [63:0]     alu_b;
    logic            alu_cin;
    logic [3:0]      alu_s;
    logic [63:0]     alu_o;
    logic            alu_cout;
    logic            alu_oflow;
    logic [64:0]     sum;

    int   n_chk = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    wide_alu_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .ci        (ci),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cout      (cout),
        .oflow     (oflow),
        .neg       (neg),
        .zero      (zero),
        .err       (err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_s     (alu_s),
        .alu_o     (alu_o),
        .alu_cout  (alu_cout),
        .alu_oflow (alu_oflow)
    );

    always #5 clk = ~clk;

    // Behavioural 64-bit combinational ALU
    always_comb begin
        sum       = {1'b0, alu_a} + {1'b0, alu_b} + {64'd0, alu_cin};
        alu_o     = alu_a;
        alu_cout  = 1'b0;
        alu_oflow = 1'b0;
        case (alu_s)
            ALU_ADDC: begin
                alu_o     = sum[63:0];
                alu_cout  = sum[64];
                alu_oflow = (alu_a[63] == alu_b[63]) && (sum[63] != alu_a[63]);
            end
            ALU_AND: alu_o = alu_a & alu_b;
            ALU_OR:  alu_o = alu_a | alu_b;
            ALU_XOR: alu_o = alu_a ^ alu_b;
            default: alu_o = alu_a;
        endcase
    end

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic c);
        exp_t         e;
        logic [W:0]   s;
        logic [W-1:0] r;
        e.cout = 1'b0; e.oflow = 1'b0; e.err = 1'b0; e.chk_flags = 1'b1;
        r = '0;
        case (o)
            OP_ADD: begin
                s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
                r = s[W-1:0]; e.cout = s[W];
                e.oflow = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            OP_SUB: begin
                s = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
                r = s[W-1:0]; e.cout = s[W];
                e.oflow = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_XOR: r = x ^ y;
            OP_SHL1: begin
                r = {x[W-2:0], c}; e.cout = x[W-1];
                e.oflow = x[W-1] ^ x[W-2];
            end
            default: begin
                e.err = 1'b1; e.chk_flags = 1'b0;
            end
        endcase
        e.res  = r;
        e.neg  = r[W-1];
        e.zero = (r == '0);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Scoreboard: every done pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_cnt++;
            chk("busy_in_done", {{(W-1){1'b0}}, busy}, 1);
            chk("sb_has_entry", (sb.size() != 0) ? 1 : 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("err", {{(W-1){1'b0}}, err}, {{(W-1){1'b0}}, e.err});
                if (e.chk_flags)
                    chk("flags", {cout, oflow, neg, zero},
                        {e.cout, e.oflow, e.neg, e.zero});
            end
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] xa,
                         input logic [W-1:0] xb, input logic xci,
                         input int exp_lat, input logic [WORDS-1:0] exp_cin,
                         input logic chk_cin);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; a = xa; b = xb; ci = xci;
        sb.push_back(model(o, xa, xb, xci));
        @(negedge clk);
        start = 1'b0; a = ~xa; b = ~xb; ci = ~xci; op = OP_AND;
        n = 1;
        while (!done && n < 40) begin
            if (chk_cin && n <= WORDS)
                chk($sformatf("cin_slice%0d", n - 1),
                    {{(W-1){1'b0}}, alu_cin},
                    {{(W-1){1'b0}}, exp_cin[n-1]});
            @(negedge clk);
            n++;
        end
        chk("done_seen", {{(W-1){1'b0}}, done}, 1);
        chk("latency", n, exp_lat);
    endtask

    initial begin
        int d0;
        logic [W-1:0] ones;
        logic [W-1:0] maxpos;
        logic [W-1:0] x;
        logic [W-1:0] y;
        ones   = '1;
        maxpos = {1'b0, {(W-1){1'b1}}};
        rst = 1'b1; start = 1'b0; op = OP_ADD; ci = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {busy, done, cout, oflow, neg, zero, err, alu_cin, alu_s}, 0);
        chk("rst_result", result, 0);
        chk("rst_alu_ab", {alu_a, alu_b}, 0);
        rst = 1'b0;

        do_op(OP_ADD, ones, 1, 1'b0, WORDS + 1, 4'b1110, 1'b1);
        do_op(OP_SUB, 0, 1, 1'b0, WORDS + 1, 4'b0001, 1'b1);
        do_op(OP_ADD, maxpos, 1, 1'b0, WORDS + 1, 4'b1110, 1'b1);
        x = '0; x[W-1] = 1'b1; x[0] = 1'b1;
        do_op(OP_SHL1, x, 0, 1'b1, WORDS + 1, 4'b0001, 1'b1);
        x = {(W/32){32'hDEADBEEF}};
        do_op(OP_XOR, x, x, 1'b1, WORDS + 1, 4'b0000, 1'b1);
        do_op(3'd6, x, x, 1'b0, 1, 4'b0000, 1'b0);
        chk("idle_alu_s", {{(W-4){1'b0}}, alu_s}, 0);
        x = rnd(); y = rnd();
        do_op(OP_AND, x, y, 1'b1, WORDS + 1, 4'b0000, 1'b1);
        do_op(OP_OR, x, y, 1'b0, WORDS + 1, 4'b0000, 1'b1);
        do_op(OP_SUB, x, y, 1'b0, WORDS + 1, 4'b0000, 1'b0);
        do_op(OP_ADD, x, y, 1'b1, WORDS + 1, 4'b0000, 1'b0);

        // start held high through the whole operation
        @(negedge clk);
        x = rnd(); y = rnd();
        start = 1'b1; op = OP_ADD; a = x; b = y; ci = 1'b0;
        sb.push_back(model(OP_ADD, x, y, 1'b0));
        d0 = done_cnt;
        repeat (WORDS + 2) begin
            @(negedge clk);
            a = rnd(); b = rnd(); op = OP_XOR;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("one_done", done_cnt - d0, 1);

        // reset on the second RUN cycle aborts the operation
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = ones; b = ones; ci = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ctl", {busy, done, cout, oflow, neg, zero, err, alu_cin, alu_s}, 0);
        chk("abort_result", result, 0);
        chk("abort_alu_ab", {alu_a, alu_b}, 0);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (WORDS + 3) @(negedge clk);
        chk("no_done_after_rst", done_cnt - d0, 0);

        do_op(OP_ADD, 5, 7, 1'b0, WORDS + 1, 4'b0000, 1'b1);
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
